// File: rtl/rect_draw_scheduler.sv
// rect_draw_scheduler: command FIFO and sequencer in front of the rectangle renderer.
// Holds renderer attributes stable while rr_enable is high and masks early rr_done.
module rect_draw_scheduler #(
  parameter int DEPTH       = 8,
  parameter int GUARD       = 2,
  parameter int X_BITES     = 9,
  parameter int Y_BITES     = 8,
  parameter int COLOR_BITES = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [X_BITES-1:0]     cmd_origin_x,
  input  logic [Y_BITES-1:0]     cmd_origin_y,
  input  logic [X_BITES-1:0]     cmd_width,
  input  logic [Y_BITES-1:0]     cmd_height,
  input  logic [COLOR_BITES-1:0] cmd_back_color,
  input  logic                   cmd_border,
  input  logic [COLOR_BITES-1:0] cmd_border_color,
  output logic                   rr_enable,
  output logic [X_BITES-1:0]     rr_origin_x,
  output logic [Y_BITES-1:0]     rr_origin_y,
  output logic [X_BITES-1:0]     rr_width,
  output logic [Y_BITES-1:0]     rr_height,
  output logic [COLOR_BITES-1:0] rr_back_color,
  output logic                   rr_border,
  output logic [COLOR_BITES-1:0] rr_border_color,
  input  logic                   rr_done,
  output logic [$clog2(DEPTH):0] queue_count,
  output logic                   busy,
  output logic                   rect_done,
  output logic                   drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [X_BITES-1:0]     origin_x;
    logic [Y_BITES-1:0]     origin_y;
    logic [X_BITES-1:0]     width;
    logic [Y_BITES-1:0]     height;
    logic [COLOR_BITES-1:0] back_color;
    logic                   border;
    logic [COLOR_BITES-1:0] border_color;
  } rect_t;

  typedef enum logic [2:0] {
    IDLE, LOAD, ARM, DRAW, RELEASE
  } state_t;

  state_t        state;
  rect_t         mem [DEPTH];
  rect_t         cmd;
  rect_t         head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [GW-1:0] guard_cnt;
  logic          zero_area;
  logic          fire;
  logic          push;
  logic          pop;

  assign cmd = {cmd_origin_x, cmd_origin_y, cmd_width, cmd_height,
                cmd_back_color, cmd_border, cmd_border_color};
  assign head = mem[rd_ptr];

  assign cmd_ready = queue_count != FULL;
  assign busy      = (queue_count != '0) || (state != IDLE);
  assign zero_area = (cmd_width == '0) || (cmd_height == '0);
  assign fire      = cmd_valid && cmd_ready && !reset;
  assign push      = fire && !zero_area;
  assign pop       = state == LOAD;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_count <= '0;
      drop        <= 1'b0;
    end else begin
      drop <= fire && zero_area;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        queue_count <= queue_count + (AW+1)'(1);
      else if (pop && !push)
        queue_count <= queue_count - (AW+1)'(1);
    end
  end

  // LOAD is only entered with a non-empty queue, so pop never underflows.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      rr_enable       <= 1'b0;
      rect_done       <= 1'b0;
      guard_cnt       <= '0;
      rr_origin_x     <= '0;
      rr_origin_y     <= '0;
      rr_width        <= '0;
      rr_height       <= '0;
      rr_back_color   <= '0;
      rr_border       <= 1'b0;
      rr_border_color <= '0;
    end else begin
      rect_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (queue_count != '0) state <= LOAD;
        end
        LOAD: begin
          rr_origin_x     <= head.origin_x;
          rr_origin_y     <= head.origin_y;
          rr_width        <= head.width;
          rr_height       <= head.height;
          rr_back_color   <= head.back_color;
          rr_border       <= head.border;
          rr_border_color <= head.border_color;
          guard_cnt       <= '0;
          rr_enable       <= 1'b1;
          state           <= ARM;
        end
        ARM: begin
          if (guard_cnt == GW'(GUARD - 1)) state <= DRAW;
          else guard_cnt <= guard_cnt + GW'(1);
        end
        DRAW: begin
          if (rr_done) begin
            rr_enable <= 1'b0;
            rect_done <= 1'b1;
            state     <= RELEASE;
          end
        end
        RELEASE: begin
          state <= (queue_count != '0) ? LOAD : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_draw_scheduler.sv
// tb_rect_draw_scheduler: directed bench for rect_draw_scheduler.
// Renderer model drives rr_done; a negedge monitor logs draws and timing.
module tb_rect_draw_scheduler;

  localparam int DEPTH = 8;
  localparam int GUARD = 2;
  localparam int XB = 9;
  localparam int YB = 8;
  localparam int CB = 3;
  localparam int AB = 2*XB + 2*YB + 2*CB + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [XB-1:0] cmd_origin_x = '0;
  logic [YB-1:0] cmd_origin_y = '0;
  logic [XB-1:0] cmd_width = '0;
  logic [YB-1:0] cmd_height = '0;
  logic [CB-1:0] cmd_back_color = '0;
  logic          cmd_border = 1'b0;
  logic [CB-1:0] cmd_border_color = '0;
  logic          rr_enable;
  logic [XB-1:0] rr_origin_x;
  logic [YB-1:0] rr_origin_y;
  logic [XB-1:0] rr_width;
  logic [YB-1:0] rr_height;
  logic [CB-1:0] rr_back_color;
  logic          rr_border;
  logic [CB-1:0] rr_border_color;
  logic          rr_done;
  logic [$clog2(DEPTH):0] queue_count;
  logic          busy;
  logic          rect_done;
  logic          drop;

  rect_draw_scheduler #(.DEPTH(DEPTH), .GUARD(GUARD)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_origin_x(cmd_origin_x), .cmd_origin_y(cmd_origin_y),
    .cmd_width(cmd_width), .cmd_height(cmd_height),
    .cmd_back_color(cmd_back_color), .cmd_border(cmd_border),
    .cmd_border_color(cmd_border_color),
    .rr_enable(rr_enable),
    .rr_origin_x(rr_origin_x), .rr_origin_y(rr_origin_y),
    .rr_width(rr_width), .rr_height(rr_height),
    .rr_back_color(rr_back_color), .rr_border(rr_border),
    .rr_border_color(rr_border_color),
    .rr_done(rr_done),
    .queue_count(queue_count), .busy(busy),
    .rect_done(rect_done), .drop(drop)
  );

  always #10 clk = ~clk;

  // Renderer model: en_cnt is the index of the current enabled cycle.
  int en_cnt = 0;
  bit stall = 1'b0;
  bit spur = 1'b0;
  int draw_len = 12;
  always @(posedge clk) en_cnt <= rr_enable ? en_cnt + 1 : 0;
  assign rr_done = rr_enable &&
    (spur ? (en_cnt < GUARD || en_cnt >= GUARD + 5)
          : (!stall && en_cnt >= draw_len));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AB-1:0] attrs;
  assign attrs = {rr_origin_x, rr_origin_y, rr_width, rr_height,
                  rr_back_color, rr_border, rr_border_color};

  logic [AB-1:0] drawn [$];
  logic [AB-1:0] expq [$];
  int            gaps [$];
  logic [AB-1:0] held = '0;
  int rd_total = 0, drop_total = 0, unstable = 0, max_qc = 0;
  int rise_cyc = 0, fall_cyc = 0, last_high = 0, rd_cyc = 0, bf_cyc = 0;
  bit prev_en = 1'b0, prev_busy = 1'b0;

  always @(negedge clk) begin
    if (rr_enable && !prev_en) begin
      drawn.push_back(attrs);
      gaps.push_back(cyc - fall_cyc);
      held = attrs;
      rise_cyc = cyc;
    end
    if (rr_enable && prev_en && attrs != held) unstable++;
    if (!rr_enable && prev_en) begin
      fall_cyc = cyc;
      last_high = cyc - rise_cyc;
    end
    if (rect_done) begin
      rd_total++;
      rd_cyc = cyc;
    end
    if (drop) drop_total++;
    if (prev_busy && !busy) bf_cyc = cyc;
    if (int'(queue_count) > max_qc) max_qc = int'(queue_count);
    prev_en = rr_enable;
    prev_busy = busy;
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AB-1:0] mk(input int x, input int y,
      input int w, input int h, input int bc, input int b, input int brc);
    return {XB'(x), YB'(y), XB'(w), YB'(h), CB'(bc), 1'(b), CB'(brc)};
  endfunction

  function automatic logic [AB-1:0] mkf(input int i);
    return mk(i*7 + 3, i*3 + 1, i + 1, (i % 5) + 1, i % 8, i % 2,
              (i + 3) % 8);
  endfunction

  task automatic push(input logic [AB-1:0] a, output bit ok,
                      output int ecyc);
    @(negedge clk);
    {cmd_origin_x, cmd_origin_y, cmd_width, cmd_height,
     cmd_back_color, cmd_border, cmd_border_color} = a;
    cmd_valid = 1'b1;
    ok = cmd_ready && !reset;
    ecyc = cyc + 1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic push_wait(input logic [AB-1:0] a);
    bit ok;
    int e;
    int n;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 500) begin
      push(a, ok, e);
      n++;
    end
    if (ok) expq.push_back(a);
    else chk("push_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int e, base, rd0, d0, g0, acc;
    logic [AB-1:0] a;

    repeat (2) @(negedge clk);
    chk("rst_enable", 64'(rr_enable), 64'd0);
    chk("rst_count", 64'(queue_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_flags", 64'({rect_done, drop}), 64'd0);
    chk("rst_attrs", 64'(attrs), 64'd0);
    reset = 1'b0;

    // single command
    rd0 = rd_total;
    a = mk(10, 20, 4, 3, 5, 1, 2);
    push(a, ok, e);
    chk("single_accept", 64'(ok), 64'd1);
    wait_idle(200);
    chk("single_latency", 64'(rise_cyc - e), 64'd2);
    chk("single_attrs", 64'(drawn[$]), 64'(a));
    chk("single_high", 64'(last_high), 64'd13);
    chk("single_rdone", 64'(rd_total - rd0), 64'd1);
    chk("single_busy_fall", 64'(bf_cyc - rd_cyc), 64'd1);

    // spurious done during guard
    spur = 1'b1;
    rd0 = rd_total;
    a = mk(1, 2, 3, 4, 1, 0, 6);
    push(a, ok, e);
    wait_idle(200);
    chk("spur_high", 64'(last_high), 64'd8);
    chk("spur_rdone", 64'(rd_total - rd0), 64'd1);
    spur = 1'b0;

    // fill, refuse, drain with wrap
    stall = 1'b1;
    draw_len = 3;
    expq.delete();
    base = drawn.size();
    rd0 = rd_total;
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      push(mkf(i), ok, e);
      if (ok) begin
        acc++;
        expq.push_back(mkf(i));
      end
    end
    chk("fill_accepted", 64'(acc), 64'd9);
    @(negedge clk);
    chk("fill_count", 64'(queue_count), 64'd8);
    chk("fill_ready", 64'(cmd_ready), 64'd0);
    push(mkf(9), ok, e);
    chk("fill_refused", 64'(ok), 64'd0);
    stall = 1'b0;
    for (int i = 10; i < 19; i++) push_wait(mkf(i));
    wait_idle(3000);
    chk("wrap_rdone", 64'(rd_total - rd0), 64'd18);
    chk("wrap_drawn", 64'(drawn.size() - base), 64'd18);
    for (int k = 0; k < 18; k++)
      if (base + k < drawn.size() && k < expq.size())
        chk($sformatf("wrap_order%0d", k), 64'(drawn[base + k]),
            64'(expq[k]));

    // zero-area commands
    max_qc = 0;
    d0 = drop_total;
    base = drawn.size();
    push(mk(5, 5, 0, 5, 1, 1, 1), ok, e);
    chk("zero_ready", 64'(ok), 64'd1);
    push(mk(5, 5, 6, 0, 1, 1, 1), ok, e);
    a = mk(7, 8, 2, 2, 3, 1, 4);
    push(a, ok, e);
    wait_idle(200);
    chk("zero_drops", 64'(drop_total - d0), 64'd2);
    chk("zero_maxq", 64'(max_qc), 64'd1);
    chk("zero_drawn", 64'(drawn.size() - base), 64'd1);
    chk("zero_attrs", 64'(drawn[$]), 64'(a));

    // back-to-back timing
    draw_len = 4;
    g0 = gaps.size();
    for (int i = 30; i < 33; i++) push(mkf(i), ok, e);
    wait_idle(300);
    chk("b2b_draws", 64'(gaps.size() - g0), 64'd3);
    if (gaps.size() >= g0 + 3) begin
      chk("b2b_gap1", 64'(gaps[g0 + 1]), 64'd2);
      chk("b2b_gap2", 64'(gaps[g0 + 2]), 64'd2);
    end
    chk("b2b_high", 64'(last_high), 64'd5);
    chk("attr_stable", 64'(unstable), 64'd0);

    // reset during DRAW
    stall = 1'b1;
    for (int i = 20; i < 24; i++) push(mkf(i), ok, e);
    e = 0;
    while (!rr_enable && e < 100) begin
      @(negedge clk);
      e++;
    end
    chk("rst_wait_enable", 64'(rr_enable), 64'd1);
    repeat (4) @(negedge clk);
    chk("rst_pre_count", 64'(queue_count), 64'd3);
    rd0 = rd_total;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_enable", 64'(rr_enable), 64'd0);
    chk("midrst_count", 64'(queue_count), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    stall = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_no_rdone", 64'(rd_total - rd0), 64'd0);
    a = mk(33, 44, 5, 6, 7, 0, 1);
    push(a, ok, e);
    wait_idle(200);
    chk("post_rst_rdone", 64'(rd_total - rd0), 64'd1);
    chk("post_rst_attrs", 64'(drawn[$]), 64'(a));
    chk("final_stable", 64'(unstable), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
